axil_cmd_master: RTL and testbench

//  Single-outstanding AXI-Lite master feeding one slave port of the RDMA 3-to-1 AXI-Lite crossbar
//  (e.g. recv or stat port). Converts a valid/ready command stream (read or write, addr, data) into
//  AXI-Lite transactions and returns a valid/ready response stream (rdata, resp).

---
 rtl/axil_cmd_pkg.sv | 33 +++
 rtl/axil_cmd_master.sv | 182 ++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_pkg.sv
// Shared types and constants for the AXI-Lite command master.
package axil_cmd_pkg;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned WD_W        = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RDATA,
        RSP
    } axil_cmd_state_e;

    typedef struct packed {
        logic                   wr;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
    } axil_cmd_t;

    typedef struct packed {
        logic                   wr;
        logic [AXIL_DATA_W-1:0] rdata;
        logic [1:0]             resp;
    } axil_rsp_t;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: command stream in, AXI-Lite transaction out,
// response stream back, with a per-transaction watchdog for hung slaves.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W      = AXIL_ADDR_W,
    parameter int unsigned DATA_W      = AXIL_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              axil_clk,
    input  logic              axil_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              timeout_pulse,
    output logic              timeout_sticky,
    output logic              m_axil_awvalid,
    output logic [ADDR_W-1:0] m_axil_awaddr,
    input  logic              m_axil_awready,
    output logic              m_axil_wvalid,
    output logic [DATA_W-1:0] m_axil_wdata,
    input  logic              m_axil_wready,
    input  logic              m_axil_bvalid,
    input  logic [1:0]        m_axil_bresp,
    output logic              m_axil_bready,
    output logic              m_axil_arvalid,
    output logic [ADDR_W-1:0] m_axil_araddr,
    input  logic              m_axil_arready,
    input  logic              m_axil_rvalid,
    input  logic [DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    output logic              m_axil_rready
);

    localparam logic            WD_EN   = (TIMEOUT_CYC != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    axil_cmd_state_e state;
    axil_cmd_t       cmd_q;
    axil_rsp_t       rsp_q;
    logic            aw_done;
    logic            w_done;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_fired;

    logic            acc;
    logic            busy;
    logic            busy_next;
    logic            aw_hs;
    logic            w_hs;
    logic [WD_W-1:0] cnt_next;
    logic            wd_hit;

    // The latched command and response drive the buses directly, so they stay stable while valid.
    assign m_axil_awaddr = ADDR_W'(cmd_q.addr);
    assign m_axil_araddr = ADDR_W'(cmd_q.addr);
    assign m_axil_wdata  = DATA_W'(cmd_q.wdata);
    assign rsp_wr        = rsp_q.wr;
    assign rsp_rdata     = DATA_W'(rsp_q.rdata);
    assign rsp_resp      = rsp_q.resp;

    // Watchdog: the pulse is registered against the count the next cycle will hold.
    always_comb begin
        acc       = (state == IDLE) && cmd_valid && cmd_ready;
        busy      = (state == WR) || (state == WRESP) || (state == RD) || (state == RDATA);
        aw_hs     = m_axil_awvalid && m_axil_awready;
        w_hs      = m_axil_wvalid && m_axil_wready;
        busy_next = acc || (busy && !((state == WRESP) && m_axil_bvalid)
                                 && !((state == RDATA) && m_axil_rvalid));
        cnt_next  = wd_cnt;
        if (acc) begin
            cnt_next = '0;
        end else if (busy && (wd_cnt != '1)) begin
            cnt_next = wd_cnt + WD_W'(1);
        end
        wd_hit = WD_EN && (acc || !wd_fired) && busy_next && (cnt_next == WD_LAST);
    end

    always_ff @(posedge axil_clk) begin
        if (axil_rst) begin
            state          <= IDLE;
            cmd_q          <= '0;
            rsp_q          <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            wd_cnt         <= '0;
            wd_fired       <= 1'b0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            timeout_pulse  <= 1'b0;
            timeout_sticky <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            wd_cnt        <= cnt_next;
            wd_fired      <= acc ? wd_hit : (wd_fired | wd_hit);
            timeout_pulse <= wd_hit;
            if (wd_hit) begin
                timeout_sticky <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (acc) begin
                        cmd_q     <= '{wr: cmd_wr, addr: AXIL_ADDR_W'(cmd_addr),
                                       wdata: AXIL_DATA_W'(cmd_wdata)};
                        cmd_ready <= 1'b0;
                        if (cmd_wr) begin
                            state          <= WR;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                        end else begin
                            state          <= RD;
                            m_axil_arvalid <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        m_axil_awvalid <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axil_wvalid <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state         <= WRESP;
                        m_axil_bready <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                    end
                end
                WRESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_q         <= '{wr: cmd_q.wr, rdata: '0, resp: m_axil_bresp};
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end
                RD: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_q         <= '{wr: cmd_q.wr, rdata: AXIL_DATA_W'(m_axil_rdata),
                                           resp: m_axil_rresp};
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master against a delay-programmable AXI-Lite slave model.
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_pulse, timeout_sticky;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int failures = 0;
    axil_rsp_t sb[$];

    // slave model configuration and observation
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    logic [31:0] cfg_rdata = '0;
    logic        stray_b = 1'b0;
    int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_hs_n = 0;
    logic aw_got, w_got, ar_pend, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, last_awaddr, last_wdata, last_araddr;
    logic aw_h, w_h, ar_h;

    always #5 clk = ~clk;

    axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .axil_clk(clk), .axil_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .timeout_pulse(timeout_pulse), .timeout_sticky(timeout_sticky),
        .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
        .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wready(wready),
        .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
        .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_arready(arready),
        .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rready(rready)
    );

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign bvalid  = s_bvalid | stray_b;
    assign bresp   = s_bresp;
    assign rvalid  = s_rvalid;
    assign rdata   = s_rdata;
    assign rresp   = s_rresp;
    assign aw_h    = awvalid && awready;
    assign w_h     = wvalid && wready;
    assign ar_h    = arvalid && arready;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= '0; s_rresp <= '0; s_rdata <= '0;
        end else begin
            if (aw_h) begin aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1; last_awaddr <= awaddr; end
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (w_h) begin w_cnt <= 0; w_hs_n <= w_hs_n + 1; last_wdata <= wdata; end
            else if (wvalid) w_cnt <= w_cnt + 1;
            if (ar_h) begin ar_cnt <= 0; ar_hs_n <= ar_hs_n + 1; last_araddr <= araddr; end
            else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (aw_h) aw_got <= 1'b1;
            if (w_h) w_got <= 1'b1;
            if (ar_h) ar_pend <= 1'b1;
            if (bvalid && bready) begin
                s_bvalid <= 1'b0;
                b_hs_n   <= b_hs_n + 1;
            end else if (!s_bvalid && (aw_got || aw_h) && (w_got || w_h)) begin
                if (b_wait >= b_dly) begin
                    s_bvalid <= 1'b1; s_bresp <= cfg_bresp;
                    aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
                end else b_wait <= b_wait + 1;
            end
            if (rvalid && rready) begin
                s_rvalid <= 1'b0;
            end else if (!s_rvalid && (ar_pend || ar_h)) begin
                if (r_wait >= r_dly) begin
                    s_rvalid <= 1'b1; s_rdata <= cfg_rdata; s_rresp <= cfg_rresp;
                    ar_pend <= 1'b0; r_wait <= 0;
                end else r_wait <= r_wait + 1;
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output bit ok);
        int n = 0;
        cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok = (cmd_ready === 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output axil_rsp_t got);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        ok  = (rsp_valid === 1'b1);
        got = '{wr: rsp_wr, rdata: rsp_rdata, resp: rsp_resp};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
             timeout_pulse, timeout_sticky} !== 9'b0) begin
            failures++;
            $display("FAIL reset_values got=%b required=0", {cmd_ready, awvalid, wvalid, bready,
                     arvalid, rready, rsp_valid, timeout_pulse, timeout_sticky});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready got=%b required=1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        bit ok; axil_rsp_t exp, got;
        aw_dly = 0; w_dly = 0; b_dly = 0; cfg_bresp = RESP_OKAY; rsp_ready = 1'b1;
        sb.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_OKAY});
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, ok);
        checks++;
        if (!ok || {awvalid, wvalid, bready, cmd_ready} !== 4'b1100 || awaddr !== 32'h10
            || wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr0_n1 aw/w/b/rdy=%b%b%b%b addr=%h data=%h required 1100 10 deadbeef",
                     awvalid, wvalid, bready, cmd_ready, awaddr, wdata);
        end
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL wr0_n2 aw/w/b/rsp=%b%b%b%b required 0010", awvalid, wvalid, bready, rsp_valid);
        end
        @(negedge clk);
        got = '{wr: rsp_wr, rdata: rsp_rdata, resp: rsp_resp};
        exp = sb.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || bready !== 1'b0 || got !== exp) begin
            failures++;
            $display("FAIL wr0_n3 rsp_valid=%b bready=%b got=%h required=%h", rsp_valid, bready, got, exp);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr0_n4 rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write_w_first();
        bit ok; axil_rsp_t exp, got; int b0, w0;
        aw_dly = 3; w_dly = 0; b_dly = 0; cfg_bresp = RESP_SLVERR;
        b0 = b_hs_n; w0 = w_hs_n;
        sb.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_SLVERR});
        send_cmd(1'b1, 32'h14, 32'h0BADF00D, ok);
        @(negedge clk);
        checks++;
        if (!ok || {awvalid, wvalid} !== 2'b10) begin
            failures++; $display("FAIL wfirst_drop aw/w=%b%b required 10", awvalid, wvalid);
        end
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h14) begin
            failures++;
            $display("FAIL wfirst_hold aw/w/b=%b%b%b addr=%h required 100 14", awvalid, wvalid, bready, awaddr);
        end
        wait_rsp(ok, got);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++; $display("FAIL wfirst_rsp ok=%0d got=%h required=%h", ok, got, exp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (b_hs_n - b0 != 1 || w_hs_n - w0 != 1 || last_wdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL wfirst_counts b=%0d w=%0d wdata=%h required 1 1 0badf00d",
                     b_hs_n - b0, w_hs_n - w0, last_wdata);
        end
        aw_dly = 0;
    endtask

    task automatic test_read();
        bit ok; axil_rsp_t exp, got;
        ar_dly = 0; r_dly = 3; cfg_rdata = 32'hCAFEF00D; cfg_rresp = RESP_SLVERR;
        sb.push_back('{wr: 1'b0, rdata: 32'hCAFEF00D, resp: RESP_SLVERR});
        send_cmd(1'b0, 32'h20, 32'h12345678, ok);
        checks++;
        if (!ok || {arvalid, awvalid, wvalid} !== 3'b100 || araddr !== 32'h20) begin
            failures++;
            $display("FAIL rd_issue ar/aw/w=%b%b%b addr=%h required 100 20", arvalid, awvalid, wvalid, araddr);
        end
        @(negedge clk);
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            failures++; $display("FAIL rd_rready ar/r=%b%b required 01", arvalid, rready);
        end
        wait_rsp(ok, got);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++; $display("FAIL rd_rsp ok=%0d got=%h required=%h", ok, got, exp);
        end
        r_dly = 0;
    endtask

    task automatic test_rsp_backpressure();
        bit ok; axil_rsp_t exp, snap, got; int n = 0; int aw0, ar0;
        cfg_bresp = RESP_DECERR; rsp_ready = 1'b0;
        sb.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_DECERR});
        send_cmd(1'b1, 32'h30, 32'h55AA55AA, ok);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h40;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        snap = '{wr: rsp_wr, rdata: rsp_rdata, resp: rsp_resp};
        exp  = sb.pop_front();
        checks++;
        if (!ok || rsp_valid !== 1'b1 || snap !== exp) begin
            failures++; $display("FAIL bp_rsp valid=%b got=%h required=%h", rsp_valid, snap, exp);
        end
        aw0 = aw_hs_n; ar0 = ar_hs_n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = '{wr: rsp_wr, rdata: rsp_rdata, resp: rsp_resp};
            checks++;
            if (rsp_valid !== 1'b1 || got !== snap || {cmd_ready, awvalid, arvalid} !== 3'b000) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b got=%h required=%h rdy/aw/ar=%b%b%b required 000",
                         i, rsp_valid, got, snap, cmd_ready, awvalid, arvalid);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || aw_hs_n != aw0 || ar_hs_n != ar0) begin
            failures++;
            $display("FAIL bp_release valid=%b rdy=%b new_aw=%0d new_ar=%0d required 0 1 0 0",
                     rsp_valid, cmd_ready, aw_hs_n - aw0, ar_hs_n - ar0);
        end
        checks++;
        if (timeout_sticky !== 1'b0) begin
            failures++; $display("FAIL no_timeout_yet sticky=%b required=0", timeout_sticky);
        end
        cfg_bresp = RESP_OKAY;
    endtask

    task automatic test_back_to_back();
        bit ok; axil_rsp_t exp, got; logic wr; logic [31:0] a, d;
        for (int i = 0; i < 6; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = {$urandom_range(0, 255), 2'b00};
            d  = $urandom;
            aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); b_dly = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
            cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            cfg_rdata = $urandom;
            sb.push_back('{wr: wr, rdata: wr ? 32'h0 : cfg_rdata, resp: wr ? cfg_bresp : cfg_rresp});
            send_cmd(wr, a, d, ok);
            wait_rsp(ok, got);
            exp = sb.pop_front();
            checks++;
            if (!ok || got !== exp || (wr ? (last_awaddr !== a || last_wdata !== d) : (last_araddr !== a))) begin
                failures++;
                $display("FAIL b2b_%0d ok=%0d got=%h required=%h awaddr=%h wdata=%h araddr=%h sent %h %h",
                         i, ok, got, exp, last_awaddr, last_wdata, last_araddr, a, d);
            end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    endtask

    task automatic test_timeout();
        bit ok; int pulses = 0;
        ar_dly = 100000;
        send_cmd(1'b0, 32'h50, 32'h0, ok);
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if (!ok || timeout_pulse !== 1'(k == 8) || arvalid !== 1'b1) begin
                failures++;
                $display("FAIL timeout_cyc%0d pulse=%b required=%b arvalid=%b required=1",
                         k, timeout_pulse, 1'(k == 8), arvalid);
            end
            if (timeout_pulse === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1 || timeout_sticky !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky pulses=%0d sticky=%b required 1 1", pulses, timeout_sticky);
        end
    endtask

    task automatic test_reset_in_wresp();
        bit ok; int n = 0; int b0; axil_rsp_t exp, got;
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        ar_dly = 0; b_dly = 100000;
        checks++;
        if (timeout_sticky !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_clear sticky=%b cmd_ready=%b required 0 1", timeout_sticky, cmd_ready);
        end
        send_cmd(1'b1, 32'h60, 32'h01020304, ok);
        while (bready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!ok || bready !== 1'b1) begin
            failures++; $display("FAIL rst_reach_wresp bready=%b required=1", bready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
             timeout_pulse, timeout_sticky} !== 9'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b required=0", {cmd_ready, awvalid, wvalid, bready,
                     arvalid, rready, rsp_valid, timeout_pulse, timeout_sticky});
        end
        rst = 1'b0; b_dly = 0; b0 = b_hs_n;
        stray_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bready !== 1'b0 || rsp_valid !== 1'b0 || b_hs_n != b0) begin
                failures++;
                $display("FAIL stray_b cyc=%0d bready=%b rsp_valid=%b b_hs=%0d required 0 0 0",
                         i, bready, rsp_valid, b_hs_n - b0);
            end
        end
        stray_b = 1'b0;
        cfg_rdata = 32'hA5A5_0001; cfg_rresp = RESP_OKAY;
        sb.push_back('{wr: 1'b0, rdata: 32'hA5A5_0001, resp: RESP_OKAY});
        send_cmd(1'b0, 32'h70, 32'h0, ok);
        wait_rsp(ok, got);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++; $display("FAIL rst_recover ok=%0d got=%h required=%h", ok, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_write_zero_wait();
        test_write_w_first();
        test_read();
        test_rsp_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_in_wresp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "global timeout");
    end

endmodule
